// File: rtl/uart_pkg.sv
// Shared receiver types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int DATA_BITS            = 8;
    localparam int CLK_PER_HALF_BIT_DEF = 434;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is taken only when a pop frees a slot on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head is gated so the output reads zero while empty, including in reset.
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];
    assign level = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver sampling mid-bit, feeding a show-ahead byte FIFO with framing and overrun pulses.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = CLK_PER_HALF_BIT_DEF,
    parameter int FIFO_DEPTH       = 16,
    localparam int LW              = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          rxd,
    output logic [7:0]    rdata,
    output logic          rvalid,
    input  logic          rready,
    output logic [LW-1:0] level,
    output logic          ferr,
    output logic          overrun
);

    localparam int CW = $clog2(2 * CLK_PER_HALF_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_HALF_BIT - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(2 * CLK_PER_HALF_BIT - 1);

    rx_state_t            state_q, state_d;
    logic                 meta_q, rxs_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 push_req, fifo_full, fifo_empty, pop;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_q <= 1'b1;
            rxs_q  <= 1'b1;
        end else begin
            meta_q <= rxd;
            rxs_q  <= meta_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        push_req = 1'b0;
        ferr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxs_q) begin
                    state_d = START;
                    bit_d   = '0;
                end
            end
            START: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rxs_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == BW'(DATA_BITS - 1)) state_d = STOP;
                end
            end
            STOP: begin
                // Leave at mid-stop so a start bit right after is not missed.
                if (cnt_q == FULL_LAST) begin
                    cnt_d    = '0;
                    state_d  = IDLE;
                    push_req = rxs_q;
                    ferr_d   = !rxs_q;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign pop   = rvalid && rready;
    assign ovr_d = push_req && fifo_full && !pop;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push_req),
        .wdata (shift_d),
        .pop   (pop),
        .rdata (rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign rvalid  = !fifo_empty;
    assign ferr    = ferr_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frames are bit-banged on rxd, expected bytes queued and checked on pop.
module tb_uart_rx_fifo;

    localparam int HB    = 4;
    localparam int DEPTH = 4;
    localparam int BIT   = 2 * HB;

    logic       clk = 1'b0;
    logic       rstn, rxd, rready;
    logic [7:0] rdata;
    logic       rvalid, ferr, overrun;
    logic [2:0] level;

    int n_cmp = 0, n_err = 0;
    int ferr_cnt = 0, ovr_cnt = 0, rv_cycles = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK_PER_HALF_BIT (HB),
        .FIFO_DEPTH       (DEPTH)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .rxd     (rxd),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .rready  (rready),
        .level   (level),
        .ferr    (ferr),
        .overrun (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        idle(BIT);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            idle(BIT);
        end
        rxd = stop;
        idle(BIT);
        rxd = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        idle(2);
        #1;
        chk("drain_left", exp_q.size(), 0);
        chk("drain_level", 32'(level), 0);
    endtask

    initial begin
        rstn   = 1'b0;
        rxd    = 1'b1;
        rready = 1'b0;

        fork
            forever begin : monitor
                logic [7:0] e;
                @(negedge clk);
                #2;
                if (ferr)    ferr_cnt++;
                if (overrun) ovr_cnt++;
                if (rvalid)  rv_cycles++;
                if (rvalid && rready) begin
                    chk("queue_nonempty_at_pop", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("pop_rdata", 32'(rdata), 32'(e));
                    end
                end
            end
        join_none

        idle(3);
        #1;
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_ferr", 32'(ferr), 0);
        chk("rst_overrun", 32'(overrun), 0);
        @(negedge clk);
        rstn = 1'b1;
        idle(4);

        // good frame, consumer always ready: rvalid for one cycle right after the stop sample
        rready    = 1'b1;
        rv_cycles = 0;
        exp_q.push_back(8'h54);
        fork
            send(8'h54, 1'b1);
            begin
                repeat (78) @(negedge clk);
                #1;
                chk("lat_rvalid_before", 32'(rvalid), 0);
                @(negedge clk);
                #1;
                chk("lat_rvalid_after", 32'(rvalid), 1);
                chk("lat_rdata", 32'(rdata), 32'h54);
            end
        join
        idle(8);
        #1;
        chk("single_rvalid_cycle", rv_cycles, 1);
        chk("ferr_none", ferr_cnt, 0);

        // two-cycle glitch is rejected, next frame still lands
        rxd = 1'b0;
        idle(2);
        rxd = 1'b1;
        idle(24);
        #1;
        chk("glitch_level", 32'(level), 0);
        chk("glitch_ferr", ferr_cnt, 0);
        exp_q.push_back(8'h68);
        send(8'h68, 1'b1);
        idle(8);
        #1;
        chk("after_glitch_left", exp_q.size(), 0);

        // framing error drops the byte
        send(8'h65, 1'b0);
        idle(16);
        #1;
        chk("ferr_once", ferr_cnt, 1);
        chk("ferr_level", 32'(level), 0);
        exp_q.push_back(8'h41);
        send(8'h41, 1'b1);
        idle(8);
        #1;
        chk("after_ferr_left", exp_q.size(), 0);

        // fill past capacity with no consumer
        @(negedge clk);
        rready = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            if (v <= DEPTH) exp_q.push_back(8'(v));
            send(8'(v), 1'b1);
        end
        idle(2);
        #1;
        chk("full_level", 32'(level), 4);
        chk("overrun_once", ovr_cnt, 1);
        @(negedge clk);
        rready = 1'b1;
        drain();

        // full FIFO, pop coincides with the push edge: no overrun
        @(negedge clk);
        rready = 1'b0;
        for (int v = 1; v <= 4; v++) begin
            exp_q.push_back(8'(v));
            send(8'(v), 1'b1);
        end
        idle(2);
        #1;
        chk("refill_level", 32'(level), 4);
        exp_q.push_back(8'h05);
        fork
            send(8'h05, 1'b1);
            begin
                repeat (78) @(negedge clk);
                rready = 1'b1;
                @(negedge clk);
                #1;
                chk("pushpop_level", 32'(level), 4);
            end
        join
        drain();
        chk("no_new_overrun", ovr_cnt, 1);

        // reset during data bit 3 abandons the frame
        fork
            send(8'hF8, 1'b1);
            begin
                repeat (36) @(negedge clk);
                rstn = 1'b0;
                repeat (2) @(negedge clk);
                rstn = 1'b1;
            end
        join
        idle(16);
        #1;
        chk("midrst_rvalid", 32'(rvalid), 0);
        chk("midrst_level", 32'(level), 0);
        chk("midrst_ferr", ferr_cnt, 1);
        exp_q.push_back(8'hA5);
        send(8'hA5, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
